// File: rtl/manchester_pkg.sv
// Shared constants for the Manchester receive path: FSM encodings, frame length, timing helpers.
// Optional parity bit is enabled with `define MANCHESTER_PARITY_EN.
package manchester_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

`ifdef MANCHESTER_PARITY_EN
  localparam int unsigned FRAME_BITS = 9;
`else
  localparam int unsigned FRAME_BITS = 8;
`endif

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 4;

  // Mid-bit acceptance window and idle-gap length, all in clk cycles.
  function automatic int unsigned win_lo(input int unsigned half_clks);
    return (3 * half_clks) / 2;
  endfunction

  function automatic int unsigned win_hi(input int unsigned half_clks);
    return (5 * half_clks) / 2;
  endfunction

  function automatic int unsigned gap_clks(input int unsigned half_clks);
    return 2 * half_clks;
  endfunction

endpackage

// File: rtl/manchester_decoder_if.sv
// Byte output handshake of the Manchester decoder (valid/ready, data held while valid).
interface manchester_decoder_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/manchester_edge_det.sv
// Two-flop synchroniser plus previous-level flop; emits combinational rise/fall strobes.
module manchester_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o  = sync2_q;
  assign rise_c_o = sync2_q & ~prev_q;
  assign fall_c_o = ~sync2_q & prev_q;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester (IEEE 802.3) line receiver: recovers mid-bit timing and delivers bytes on valid/ready.
// Define MANCHESTER_PARITY_EN to expect and check a trailing even-parity bit.
module manchester_decoder
  import manchester_pkg::*;
#(
  parameter int unsigned HALF_CLKS = 4,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_in,
  manchester_decoder_if.master  dout_if,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int unsigned WIN_LO = win_lo(HALF_CLKS);
  localparam int unsigned WIN_HI = win_hi(HALF_CLKS);
  localparam int unsigned GAP_N  = gap_clks(HALF_CLKS);

  logic level_c;
  logic rise_c;
  logic fall_c;

  manchester_edge_det u_edge (
    .clk      (clk),
    .rst      (rst),
    .line_i   (line_in),
    .level_o  (level_c),
    .rise_c_o (rise_c),
    .fall_c_o (fall_c)
  );

  logic [1:0]            state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [BIT_W-1:0]      bit_q,    bit_d;
  logic [FRAME_BITS-2:0] shift_q,  shift_d;
  logic [BYTE_W-1:0]     data_q,   data_d;
  logic                  valid_q,  valid_d;
  logic                  busy_q,   busy_d;
  logic                  ferr_q,   ferr_d;
  logic                  ovr_q,    ovr_d;
  logic                  perr_d;

  logic                  edge_c;
  logic                  done_c;
  logic                  par_ok_c;
  logic [CNT_W-1:0]      cnt_nxt_c;
  logic [FRAME_BITS-1:0] full_c;
  logic [BYTE_W-1:0]     byte_c;

  assign edge_c    = rise_c | fall_c;
  assign cnt_nxt_c = cnt_q + CNT_W'(1);
  assign full_c    = {shift_q, rise_c};

`ifdef MANCHESTER_PARITY_EN
  assign byte_c   = full_c[FRAME_BITS-1:1];
  assign par_ok_c = ~(^full_c);
`else
  assign byte_c   = full_c;
  assign par_ok_c = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    perr_d  = 1'b0;
    done_c  = 1'b0;

    if (valid_q && dout_if.data_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Rising edge here is the start bit's mid-bit transition.
        if (rise_c) begin
          state_d = ST_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = '0;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_nxt_c;
        if (cnt_nxt_c > CNT_W'(WIN_HI)) begin
          ferr_d  = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (edge_c && (cnt_nxt_c >= CNT_W'(WIN_LO))) begin
          shift_d = full_c[FRAME_BITS-2:0];
          cnt_d   = '0;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            done_c  = 1'b1;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (level_c) begin
          cnt_d = '0;
        end else if (cnt_nxt_c >= CNT_W'(GAP_N)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_nxt_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A byte accepted this very cycle frees the slot for the new one.
    if (done_c) begin
      if (!par_ok_c) begin
        perr_d = 1'b1;
      end else if (!valid_q || dout_if.data_ready) begin
        data_d  = byte_c;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

`ifdef MANCHESTER_PARITY_EN
  logic perr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign dout_if.data_out   = data_q;
  assign dout_if.data_valid = valid_q;
  assign busy               = busy_q;
  assign frame_err          = ferr_q;
  assign overrun            = ovr_q;

endmodule

// File: tb/tb_manchester_decoder.sv
// Directed bench for manchester_decoder with HALF_CLKS=4; inputs change 2 ns after posedge, outputs sampled on negedge.
module tb_manchester_decoder;

  localparam int unsigned H = 4;

  logic clk = 1'b0;
  logic rst;
  logic line_in;
  logic busy, frame_err, overrun, parity_err;

  always #5 clk = ~clk;

  manchester_decoder_if dif ();

  manchester_decoder #(.HALF_CLKS(4), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_in    (line_in),
    .dout_if    (dif),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int checks = 0;
  int errors = 0;
  int n_acc = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      if (dif.data_valid && dif.data_ready) begin
        n_acc++;
        last_byte = dif.data_out;
      end
      if (dif.data_valid) n_vcyc++;
      if (frame_err)      n_ferr++;
      if (overrun)        n_ovr++;
      if (parity_err)     n_perr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    line_in = lvl;
    tick(n);
  endtask

  task automatic send_bit(input logic b, input int h1, input int h2);
    drive(~b, h1);
    drive(b, h2);
  endtask

  // jit=1 alternates half-bits (3,5)/(5,3) so mid-bit spacing swings 10/6.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic jit);
    int k;
    k = 0;
    if (jit) send_bit(1'b1, 3, 5); else send_bit(1'b1, H, H);
    for (int i = 7; i >= 0; i--) begin
      if (jit && (k % 2 == 0)) send_bit(d[i], 5, 3);
      else if (jit)            send_bit(d[i], 3, 5);
      else                     send_bit(d[i], H, H);
      k++;
    end
`ifdef MANCHESTER_PARITY_EN
    if (jit) send_bit((^d) ^ pflip, 5, 3); else send_bit((^d) ^ pflip, H, H);
`else
    if (pflip) k++;
`endif
    line_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 80 && busy !== 1'b0; i++) tick(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy got %b want 0 (timeout)", name, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    line_in = 1'b0;
    dif.data_ready = 1'b0;
    tick(3);
    checks++;
    if ({dif.data_out, dif.data_valid, busy, frame_err, overrun, parity_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {dif.data_out, dif.data_valid, busy, frame_err, overrun, parity_err});
    end
    rst = 1'b0;
    tick(4);
    checks++;
    if (busy !== 1'b0 || dif.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b valid %b want 0 0", busy, dif.data_valid);
    end
  endtask

  task automatic test_basic;
    int a0, v0, f0, o0;
    a0 = n_acc; v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
    dif.data_ready = 1'b1;
    send_frame(8'hA5, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_gap: got %b want 1", busy);
    end
    tick(6);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_early: got %b want 1", busy);
    end
    wait_idle("basic_idle");
    checks++;
    if (n_acc - a0 != 1 || last_byte !== 8'hA5) begin
      errors++;
      $display("FAIL basic_data: got %0d bytes last %h want 1 bytes a5", n_acc - a0, last_byte);
    end
    checks++;
    if (n_vcyc - v0 != 1) begin
      errors++;
      $display("FAIL basic_valid_width: got %0d want 1", n_vcyc - v0);
    end
    checks++;
    if (n_ferr != f0 || n_ovr != o0) begin
      errors++;
      $display("FAIL basic_no_err: ferr %0d ovr %0d want 0 0", n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_back_to_back;
    int a0, o0;
    a0 = n_acc; o0 = n_ovr;
    dif.data_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 16);
    send_frame(8'hC3, 1'b0, 1'b0);
    drive(1'b0, 4);
    wait_idle("b2b_idle");
    checks++;
    if (dif.data_out !== 8'h3C || dif.data_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: data %h valid %b want 3c 1", dif.data_out, dif.data_valid);
    end
    checks++;
    if (n_ovr - o0 != 1) begin
      errors++;
      $display("FAIL b2b_overrun: got %0d want 1", n_ovr - o0);
    end
    checks++;
    if (n_acc != a0) begin
      errors++;
      $display("FAIL b2b_no_accept: got %0d want 0", n_acc - a0);
    end
    dif.data_ready = 1'b1;
    tick(20);
    checks++;
    if (n_acc - a0 != 1 || last_byte !== 8'h3C) begin
      errors++;
      $display("FAIL b2b_drain: got %0d bytes last %h want 1 bytes 3c", n_acc - a0, last_byte);
    end
    checks++;
    if (dif.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_clear: got %b want 0", dif.data_valid);
    end
  endtask

  task automatic test_frame_err;
    int a0, f0;
    a0 = n_acc; f0 = n_ferr;
    dif.data_ready = 1'b1;
    send_bit(1'b1, H, H);
    send_bit(1'b1, H, H);
    send_bit(1'b0, H, H);
    send_bit(1'b1, H, H);
    drive(1'b1, 10);
    checks++;
    if (n_ferr != f0) begin
      errors++;
      $display("FAIL ferr_early: got %0d want 0", n_ferr - f0);
    end
    drive(1'b1, 1);
    checks++;
    if (n_ferr - f0 != 1) begin
      errors++;
      $display("FAIL ferr_pulse: got %0d want 1", n_ferr - f0);
    end
    drive(1'b1, 5);
    drive(1'b0, 4);
    wait_idle("ferr_idle");
    checks++;
    if (n_ferr - f0 != 1 || n_acc != a0 || dif.data_valid !== 1'b0) begin
      errors++;
      $display("FAIL ferr_discard: ferr %0d bytes %0d valid %b want 1 0 0",
               n_ferr - f0, n_acc - a0, dif.data_valid);
    end
  endtask

  task automatic test_jitter;
    int a0, f0;
    a0 = n_acc; f0 = n_ferr;
    dif.data_ready = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1);
    drive(1'b0, 4);
    wait_idle("jitter_idle");
    checks++;
    if (n_acc - a0 != 1 || last_byte !== 8'h81) begin
      errors++;
      $display("FAIL jitter_data: got %0d bytes last %h want 1 bytes 81", n_acc - a0, last_byte);
    end
    checks++;
    if (n_ferr != f0) begin
      errors++;
      $display("FAIL jitter_no_ferr: got %0d want 0", n_ferr - f0);
    end
  endtask

  task automatic test_reset_mid;
    int a0;
    dif.data_ready = 1'b1;
    send_bit(1'b1, H, H);
    for (int i = 0; i < 4; i++) send_bit(1'b1, H, H);
    drive(1'b0, 2);
    checks++;
    if (busy !== 1'b1 || dif.data_out !== 8'h81) begin
      errors++;
      $display("FAIL rstmid_before: busy %b data %h want 1 81", busy, dif.data_out);
    end
    rst = 1'b1;
    line_in = 1'b0;
    #1;
    checks++;
    if ({dif.data_out, dif.data_valid, busy, frame_err, overrun, parity_err} !== 13'd0) begin
      errors++;
      $display("FAIL rstmid_clear: got %h want 0",
               {dif.data_out, dif.data_valid, busy, frame_err, overrun, parity_err});
    end
    tick(2);
    rst = 1'b0;
    tick(2);
    a0 = n_acc;
    send_frame(8'h12, 1'b0, 1'b0);
    drive(1'b0, 4);
    wait_idle("rstmid_idle");
    checks++;
    if (n_acc - a0 != 1 || last_byte !== 8'h12) begin
      errors++;
      $display("FAIL rstmid_next: got %0d bytes last %h want 1 bytes 12", n_acc - a0, last_byte);
    end
  endtask

  task automatic test_parity;
`ifdef MANCHESTER_PARITY_EN
    int a0, p0, o0;
    a0 = n_acc; p0 = n_perr; o0 = n_ovr;
    dif.data_ready = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    drive(1'b0, 4);
    wait_idle("par_ok_idle");
    checks++;
    if (n_acc - a0 != 1 || last_byte !== 8'h5A || n_perr != p0) begin
      errors++;
      $display("FAIL par_ok: bytes %0d last %h perr %0d want 1 5a 0", n_acc - a0, last_byte, n_perr - p0);
    end
    a0 = n_acc;
    send_frame(8'h5A, 1'b1, 1'b0);
    drive(1'b0, 4);
    wait_idle("par_bad_idle");
    checks++;
    if (n_perr - p0 != 1 || n_acc != a0 || n_ovr != o0) begin
      errors++;
      $display("FAIL par_bad: perr %0d bytes %0d ovr %0d want 1 0 0", n_perr - p0, n_acc - a0, n_ovr - o0);
    end
`else
    checks++;
    if (n_perr != 0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL par_tied: pulses %0d level %b want 0 0", n_perr, parity_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_jitter();
    test_reset_mid();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/manchester_decoder.md
Name: manchester_decoder

Overview:
- Receive-side counterpart to the Manchester encoder.
- Consumes a serial Manchester line, recovers the mid-bit timing and reassembles 8-bit bytes.
- Presents each byte on a valid/ready interface to downstream logic.
- Sits directly downstream of the encoder's data_out line, either looped back on-chip or driven via an input pin of the tile.

Parameters:
- HALF_CLKS, 4, clk cycles per Manchester half-bit; must be even and >= 4.
- CNT_W, 4, width of the bit-timing counter; must hold 5*HALF_CLKS/2 + 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- line_in  in  1  raw Manchester line, asynchronous to clk, idle low.
- data_out  out  8  recovered byte, MSB first on the line; held stable while data_valid=1.
- data_valid  out  1  byte available.
- data_ready  in  1  consumer accepts; transfer occurs when data_valid && data_ready.
- busy  out  1  high while in DATA or GAP.
- frame_err  out  1  one-cycle pulse on a timing violation.
- overrun  out  1  one-cycle pulse when a completed byte is dropped.
- parity_err  out  1  one-cycle pulse on a parity mismatch (feature only; tied 0 otherwise).

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, shift register 0, synchroniser flops 0.
- Input path:
  - 2-flop synchroniser, then a 1-flop previous-level register.
  - rise = s & ~p; fall = ~s & p; edge = rise | fall.
  - Pin-to-edge latency is 3 clk.
- Line coding (IEEE 802.3): bit 1 = low-then-high (rising mid-bit edge); bit 0 = high-then-low (falling mid-bit edge).
- Frame: start bit '1', then 8 data bits MSB first (9 with the parity feature), then the line returns low.
- IDLE:
  - rise -> counter=0, bitcnt=0, go to DATA. The rise is the start bit's mid-bit edge.
  - fall is ignored.
- DATA:
  - Counter increments every clk.
  - Edges while counter < 3*HALF_CLKS/2 are bit-boundary transitions and are ignored.
  - Edge while 3H/2 <= counter <= 5H/2 is a mid-bit edge:
    - shift in rise (1) or fall (0); counter=0; bitcnt++.
  - Counter reaches 5H/2+1 with no mid-bit edge:
    - frame_err pulse; discard the partial byte; go to GAP.
  - After the last data (or parity) bit, the byte completes; go to GAP.
- Byte completion:
  - If data_valid=0, or data_valid=1 && data_ready=1 in the same cycle: load data_out, data_valid=1 on the next clk edge. Simultaneous accept and new byte is not an overrun.
  - Otherwise: the old byte is kept, the new byte is dropped, overrun pulse.
  - data_valid clears on the handshake.
- GAP: requires the synced line low for 2*HALF_CLKS consecutive clks, then IDLE. Any high level restarts the gap count.
- busy = (state != IDLE).
- Asynchronous rst mid-frame aborts immediately; the line must then satisfy GAP-free IDLE rules, so a subsequent rise starts a frame.

Optional Feature:
- Macro: MANCHESTER_PARITY_EN.
- Defined:
  - A 9th bit follows the data bits and carries even parity over data+parity.
  - On mismatch: parity_err pulse; the byte is discarded (no data_valid, no overrun).
- Undefined:
  - 8 data bits only.
  - parity_err is tied 0.

Decomposition:
- Package manchester_pkg:
  - state enum {IDLE, DATA, GAP}.
  - localparam helpers: WIN_LO = 3*HALF_CLKS/2, WIN_HI = 5*HALF_CLKS/2, GAP_CLKS = 2*HALF_CLKS.
  - Bit-count constant FRAME_BITS (8, or 9 with parity).
- Sub-module manchester_edge_det:
  - Contains the synchroniser, the previous-level register and the rise/fall outputs.
  - Reset is asynchronous, active-high.

Test Plan (HALF_CLKS=4, one half-bit = 4 clk):
- Frame 0xA5, data_ready=1 -> data_out=0xA5, data_valid high exactly 1 cycle, no error pulses, busy low after GAP (8 clk low).
- Frames 0x3C then 0xC3 back-to-back with data_ready=0 -> data_out stays 0x3C, one overrun pulse; after raising data_ready, 0x3C is accepted and no 0xC3 appears.
- Mid-bit edge of the 4th data bit removed (line held 16 clk) -> frame_err pulse at counter=11, no data_valid, return to IDLE after 8 low clk.
- Half-bits jittered to 3 and 5 clk on frame 0x81 -> data_out=0x81, no frame_err.
- rst asserted at data bit 5 of 0xFF -> all outputs 0 immediately; next frame 0x12 decodes correctly.
- With MANCHESTER_PARITY_EN: 0x5A with parity bit 0 -> valid 0x5A; same byte with parity bit 1 -> parity_err pulse, no data_valid.
